// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types for the DVP capture front-end (formats, FSM states,
// the pixel record carried through the output FIFO and err bit positions).
package dvp_pkg;

    // Coordinate fields in the pixel record are fixed-width so the record can
    // live in a package; the top slices them down to $clog2(WIDTH/HEIGHT).
    localparam int unsigned DVP_COORD_W = 12;

    typedef enum logic [1:0] {
        FMT_RGB888 = 2'd0,
        FMT_RGB565 = 2'd1,
        FMT_YUV422 = 2'd2,
        FMT_RSVD   = 2'd3
    } dvp_fmt_e;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_IN_VS   = 2'd1,
        ST_ACTIVE  = 2'd2
    } dvp_state_e;

    typedef struct packed {
        logic [23:0]            data;
        logic [DVP_COORD_W-1:0] x;
        logic [DVP_COORD_W-1:0] y;
        logic                   sof;
        logic                   eol;
    } dvp_pixel_t;

    localparam int unsigned ERR_LINE  = 0;
    localparam int unsigned ERR_FRAME = 1;
    localparam int unsigned ERR_OVF   = 2;

    // RRRRRGGG,GGGBBBBB -> 8:8:8 by replicating the MSBs into the low bits
    function automatic logic [23:0] rgb565_expand(input logic [7:0] b0, input logic [7:0] b1);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = b0[7:3];
        g6 = {b0[2:0], b1[7:5]};
        b5 = b1[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

endpackage

// File: rtl/dvp_fifo.sv
// dvp_fifo: synchronous show-ahead FIFO of dvp_pixel_t records.
// Head entry is visible on o_rdata whenever o_empty is low; a push into a
// full FIFO is accepted only when a pop happens on the same cycle.
module dvp_fifo
    import dvp_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  dvp_pixel_t i_wdata,
    input  logic       i_pop,
    output dvp_pixel_t o_rdata,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    dvp_pixel_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_wr;
    assign o_rdata = r_mem[r_rd_ptr];

    // storage write
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // pointer and occupancy tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dvp_capture.sv
// dvp_capture: DVP byte stream -> 24-bit tagged pixels through a small FIFO.
// Formats RGB888 / RGB565 / YUV422 selected by fmt, latched at vsync fall.
// Optional macro DVP_ERR_CHECK_EN enables the sticky err register; without
// it err reads 0 and err_clr is ignored.
module dvp_capture
    import dvp_pkg::*;
#(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned FIFO_DEPTH = 16
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vsync,
    input  logic                      href,
    input  logic [7:0]                data,
    input  logic [1:0]                fmt,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [23:0]               pix_data,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic                      frame_done,
    output logic [2:0]                err,
    input  logic                      err_clr
);

    localparam int unsigned XW  = $clog2(WIDTH);
    localparam int unsigned YW  = $clog2(HEIGHT);
    localparam int unsigned XCW = $clog2(WIDTH + 1);

    dvp_state_e     r_state;
    dvp_fmt_e       r_fmt;
    logic           r_href_d;
    logic [1:0]     r_phase;
    logic [7:0]     r_b0;
    logic [7:0]     r_b1;
    logic [7:0]     r_b2;
    logic [7:0]     r_v;
    logic           r_yuv_pend;
    logic [XCW-1:0] r_x;
    logic [YW-1:0]  r_y;
    logic           r_over;
    dvp_pixel_t     r_stg;
    logic           r_stg_vld;
    logic           r_frame_done;

    logic           w_abort;
    logic           w_byte;
    logic           w_href_rise;
    logic           w_line_end;
    logic           w_vs_fall;
    logic [1:0]     w_phase;
    logic [1:0]     w_phase_nxt;
    logic           w_complete;
    logic [23:0]    w_pix_data;
    logic           w_yuv_second;
    logic           w_cand;
    logic [23:0]    w_stg_data;
    logic           w_stage;
    logic           w_excess;
    logic [XCW-1:0] w_cnt_end;
    logic           w_line_bad;
    logic           w_ev_ovf;
    logic           w_ev_frame;
    logic           w_ev_line;

    dvp_pixel_t     w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_drop;
    logic           w_unused_misc;

    // byte decode, pixel assembly and line-end qualification
    always_comb begin
        w_abort      = (r_state == ST_ACTIVE) && vsync;
        w_byte       = (r_state == ST_ACTIVE) && !vsync && href;
        w_href_rise  = href && !r_href_d;
        w_line_end   = (r_state == ST_ACTIVE) && !vsync && !href && r_href_d;
        w_vs_fall    = (r_state == ST_IN_VS) && !vsync;
        w_phase      = w_href_rise ? 2'd0 : r_phase;
        w_phase_nxt  = w_phase;
        w_complete   = 1'b0;
        w_pix_data   = '0;
        if (w_byte) begin
            case (r_fmt)
                FMT_RGB888: begin
                    if (w_phase == 2'd2) begin
                        w_complete  = 1'b1;
                        w_pix_data  = {r_b0, r_b1, data};
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_phase_nxt = w_phase + 2'd1;
                    end
                end
                FMT_RGB565: begin
                    if (w_phase == 2'd1) begin
                        w_complete  = 1'b1;
                        w_pix_data  = rgb565_expand(r_b0, data);
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_phase_nxt = w_phase + 2'd1;
                    end
                end
                FMT_YUV422: begin
                    if (w_phase == 2'd3) begin
                        w_complete  = 1'b1;
                        w_pix_data  = {r_b0, r_b1, data};
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_phase_nxt = w_phase + 2'd1;
                    end
                end
                default: w_phase_nxt = 2'd0;
            endcase
        end
        // the Y1 pixel of a YUV pair is staged one cycle after V, and may
        // coincide with the href fall that ends the line
        w_yuv_second = r_yuv_pend && (r_state == ST_ACTIVE) && !vsync;
        w_cand       = w_complete || w_yuv_second;
        w_stg_data   = w_complete ? w_pix_data : {r_b2, r_b1, r_v};
        w_stage      = w_cand && (r_x < XCW'(WIDTH));
        w_excess     = w_cand && !(r_x < XCW'(WIDTH));
        w_cnt_end    = w_stage ? (r_x + XCW'(1)) : r_x;
        w_line_bad   = (r_phase != 2'd0) || (w_cnt_end != XCW'(WIDTH)) || r_over || w_excess;
        w_ev_ovf     = w_drop;
        w_ev_frame   = w_abort || (w_vs_fall && (fmt == 2'd3));
        w_ev_line    = w_line_end && w_line_bad;
    end

    // frame FSM, byte capture, coordinates and the one-deep staging register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_VS;
            r_fmt        <= FMT_RGB888;
            r_href_d     <= 1'b0;
            r_phase      <= '0;
            r_b0         <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_v          <= '0;
            r_yuv_pend   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_over       <= 1'b0;
            r_stg        <= '0;
            r_stg_vld    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_href_d     <= href;
            r_frame_done <= 1'b0;
            r_stg_vld    <= w_stage;
            if (w_stage) begin
                r_stg <= '{data: w_stg_data,
                           x:    DVP_COORD_W'(r_x),
                           y:    DVP_COORD_W'(r_y),
                           sof:  (r_x == '0) && (r_y == '0),
                           eol:  (r_x == XCW'(WIDTH - 1))};
            end
            case (r_state)
                ST_WAIT_VS: begin
                    if (vsync) begin
                        r_state <= ST_IN_VS;
                    end
                end
                ST_IN_VS: begin
                    if (!vsync) begin
                        r_fmt      <= dvp_fmt_e'(fmt);
                        r_phase    <= '0;
                        r_yuv_pend <= 1'b0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_over     <= 1'b0;
                        r_state    <= (fmt == 2'd3) ? ST_WAIT_VS : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_abort) begin
                        r_state    <= ST_IN_VS;
                        r_phase    <= '0;
                        r_yuv_pend <= 1'b0;
                    end else begin
                        if (w_yuv_second) begin
                            r_yuv_pend <= 1'b0;
                        end
                        if (w_byte) begin
                            r_phase <= w_phase_nxt;
                            case (w_phase)
                                2'd0:    r_b0 <= data;
                                2'd1:    r_b1 <= data;
                                2'd2:    r_b2 <= data;
                                default: r_b2 <= r_b2;
                            endcase
                            if (w_complete && (r_fmt == FMT_YUV422)) begin
                                r_v        <= data;
                                r_yuv_pend <= 1'b1;
                            end
                        end
                        if (w_line_end) begin
                            r_x     <= '0;
                            r_over  <= 1'b0;
                            r_phase <= '0;
                            r_y     <= r_y + YW'(1);
                            if (r_y == YW'(HEIGHT - 1)) begin
                                r_state      <= ST_WAIT_VS;
                                r_frame_done <= 1'b1;
                            end
                        end else begin
                            if (w_stage) begin
                                r_x <= r_x + XCW'(1);
                            end
                            if (w_excess) begin
                                r_over <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= ST_WAIT_VS;
            endcase
        end
    end

    dvp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (r_stg_vld),
        .i_wdata (r_stg),
        .i_pop   (pix_ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign pix_valid  = !w_empty;
    assign pix_data   = pix_valid ? w_head.data : '0;
    assign pix_x      = pix_valid ? w_head.x[XW-1:0] : '0;
    assign pix_y      = pix_valid ? w_head.y[YW-1:0] : '0;
    assign pix_sof    = pix_valid && w_head.sof;
    assign pix_eol    = pix_valid && w_head.eol;
    assign frame_done = r_frame_done;

    // full flag and the upper coordinate bits are not needed at this level
    assign w_unused_misc = ^{w_full, w_head.x, w_head.y};

`ifdef DVP_ERR_CHECK_EN
    logic [2:0] r_err;

    // sticky error flags; a clear wins over a same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= '0;
        end else begin
            if (w_ev_ovf) begin
                r_err[ERR_OVF] <= 1'b1;
            end
            if (w_ev_frame) begin
                r_err[ERR_FRAME] <= 1'b1;
            end
            if (w_ev_line) begin
                r_err[ERR_LINE] <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = ^{err_clr, w_ev_ovf, w_ev_frame, w_ev_line};
    assign err = '0;
`endif

endmodule

// File: doc/dvp_capture.md
# dvp_capture

Parametrised DVP camera capture front-end for the JPEG encoder path. It samples an 8-bit DVP byte stream (vsync/href framed) and assembles bytes into 24-bit pixels for three runtime-selectable formats. Pixels are tagged with x/y coordinates and start/end markers, then delivered through a small FIFO with valid/ready handshake so the downstream colour-convert/DCT stage may stall. Replaces the fixed-format, fixed-geometry capture block.

## Interface
- WIDTH, 640: active pixels per line
- HEIGHT, 480: active lines per frame
- FIFO_DEPTH, 16: output FIFO entries, power of two, ≥4
- clk  input  1  pixel-byte clock; DVP inputs change on falling edge, sampled on rising
- rst_n  input  1  asynchronous active-low reset
- vsync  input  1  frame sync, active high
- href  input  1  line valid, active high
- data  input  8  DVP byte
- fmt  input  2  pixel format: 0 RGB888, 1 RGB565, 2 YUV422, 3 reserved; latched on vsync falling edge
- pix_valid  output  1  FIFO head valid
- pix_ready  input  1  downstream accept
- pix_data  output  24  {c0,c1,c2} = {R,G,B} or {Y,U,V}
- pix_x  output  $clog2(WIDTH)  column of head pixel
- pix_y  output  $clog2(HEIGHT)  row of head pixel
- pix_sof  output  1  head is pixel (0,0)
- pix_eol  output  1  head is pixel x=WIDTH-1
- frame_done  output  1  one-cycle pulse when line HEIGHT-1 ends
- err  output  3  sticky {overflow, frame_err, line_err}
- err_clr  input  1  clears err

## Operation
- Reset: all outputs 0, FIFO empty, state WAIT_VS, latched format 0.
- FSM: WAIT_VS → (vsync=1) IN_VS → (vsync 1→0; latch fmt) ACTIVE → (line HEIGHT-1 ends) WAIT_VS with frame_done pulse. Latched fmt=3: go to WAIT_VS, set frame_err.
- vsync=1 while ACTIVE: abort frame, drop partial pixel, set frame_err, go IN_VS. Pixels already in FIFO are kept.
- Byte phase counter clears on href rising edge.
- RGB888: bytes R,G,B.
- RGB565: byte0 = RRRRRGGG, byte1 = GGGBBBBB. Expand by MSB replication: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 likewise.
- YUV422: bytes Y0,U,Y1,V. Push {Y0,U,V} on the cycle after V is sampled and {Y1,U,V} on the following cycle. At most one push per cycle.
- x increments per pushed pixel. A line ends on href falling:
  - y increments; x clears.
  - Partial pixel at href fall: discarded, set line_err.
  - Pixel count ≠ WIDTH: set line_err; pixels past WIDTH-1 are dropped.
- FIFO full on push: pixel dropped, overflow set. Coordinates still advance so downstream can resynchronise.
- err_clr has priority over a same-cycle set. Bits are cleared that cycle and the new event is lost.

## Timing
- Byte completing a pixel is sampled at edge E. FIFO write occurs at edge E+1. pix_valid is high after edge E+1 if the FIFO was empty.
- YUV422 second pixel: written at E+2.
- Transfer occurs on pix_valid & pix_ready. Head outputs are stable while valid and not ready.
- Simultaneous push and pop on a full FIFO: push accepted, no overflow.
- Sustained throughput: one pixel per 3 (RGB888), 2 (RGB565) or 2 (YUV422) byte cycles.
- frame_done pulses at the edge after the final href fall.

## Configuration
- DVP_ERR_CHECK_EN defined: line/frame/overflow detection and the err register as above.
- DVP_ERR_CHECK_EN undefined: err tied to 0, err_clr ignored.
- Drop-on-full, line truncation and vsync abort behave identically in both builds.

## Structure
- dvp_pkg:
  - dvp_fmt_e enum (FMT_RGB888, FMT_RGB565, FMT_YUV422, FMT_RSVD)
  - dvp_state_e enum
  - pixel struct {data, x, y, sof, eol}
  - err bit indices
- Sub-module dvp_fifo: synchronous show-ahead FIFO of the pixel struct, parameter DEPTH, full/empty flags.

## Test plan
- RGB888, WIDTH=10, HEIGHT=16, every pixel bytes 1,2,3, pix_ready=1 → 160 pixels of 0x010203 with x 0..9, y 0..15; sof once, eol 16×, frame_done once, err=0.
- RGB565, bytes 0xF8,0x1F → pix_data 0xFF00FF; bytes 0x07,0xE0 → 0x00FF00.
- YUV422, line bytes 0x10,0x80,0x20,0x90 repeated → pixels 0x108090, 0x208090 alternating, 10 per line.
- pix_ready=0 for a full line of RGB888, WIDTH=10, FIFO_DEPTH=4 → 4 pixels held (x 0..3), err=3'b100; with macro undefined, err stays 0.
- href dropped after 29 bytes (RGB888) → 9 pixels, line_err set, next line starts at x=0, y+1.
- vsync reasserted at line 5 → frame_err set, new frame restarts at y=0 with sof; fmt=3 at vsync fall → no pixels, frame_err.
